maincontrol: RTL and testbench
==============================

# maincontrol

Multicycle main control unit for the 8-bit MIPS datapath. A Moore state machine fetches a 32-bit instruction over four byte-wide memory reads, decodes the 6-bit opcode, and sequences datapath enables for lb, sb, addi, beq, j and R-type instructions. It drives the 2-bit `aluop` consumed by `alucontrol`: 00 = add, 01 = subtract, 10 = decode `funct`.

## Interface
- No parameters.
- `clk` in 1: clock; all state changes occur on its rising edge.
- `reset` in 1: asynchronous, active-high reset; forces `state` to FETCH1.
- `op` in 6: instruction opcode, IR[31:26].
- `zero` in 1: ALU zero flag.
- `memread` out 1: memory read strobe.
- `memwrite` out 1: memory write strobe.
- `alusrca` out 1: ALU A select; 0 = PC, 1 = register A.
- `alusrcb` out 2: ALU B select; 00 = reg B, 01 = constant 1, 10 = imm, 11 = imm branch offset.
- `memtoreg` out 1: register-file write data; 1 = MDR, 0 = ALUOut.
- `iord` out 1: memory address; 0 = PC, 1 = ALUOut.
- `regwrite` out 1: register-file write enable.
- `regdst` out 1: destination register; 1 = rd, 0 = rt.
- `pcsource` out 2: next-PC select; 00 = ALU, 01 = ALUOut, 10 = jump target.
- `pcen` out 1: PC load enable.
- `irwrite` out 4: one-hot IR byte-lane write enable.
- `aluop` out 2: to `alucontrol`.
- `state` out 4: current state, for debug and verification.

## Operation
- State encoding (4-bit): FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4, MEMADR=5, LBRD=6, LBWR=7, SBWR=8, RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12, ADDIEX=13, ADDIWR=14, BNEEX=15.
- Outputs are a pure decode of `state`. Any signal not listed for a state is 0.
- FETCHn (n = 1..4):
  - Outputs: memread=1, `irwrite` bit n-1 = 1, alusrcb=01, aluop=00, pcsource=00, pcwrite=1.
  - Each fetch cycle advances PC by 1.
  - Transitions: FETCH1→FETCH2→FETCH3→FETCH4→DECODE.
- DECODE:
  - Outputs: alusrcb=11, aluop=00 (precomputes the branch target).
  - `op` is sampled here.
  - Transitions: 100000/101000 (lb/sb)→MEMADR; 000000→RTYPEEX; 000100→BEQEX; 000010→JEX; 001000→ADDIEX; any other opcode→FETCH1, with no write side effects.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lb→LBRD, sb→SBWR.
- LBRD: memread=1, iord=1 → LBWR.
- LBWR: regwrite=1, memtoreg=1, regdst=0 → FETCH1.
- SBWR: memwrite=1, iord=1 → FETCH1.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 → RTYPEWR.
- RTYPEWR: regwrite=1, regdst=1, memtoreg=0 → FETCH1.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsource=01, branch=1 → FETCH1.
- JEX: pcwrite=1, pcsource=10 → FETCH1.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 → ADDIWR.
- ADDIWR: regwrite=1, regdst=0, memtoreg=0 → FETCH1.
- `pcen` = pcwrite | (branch & zero) | (branchne & ~zero). `branchne` is nonzero only in BNEEX.
- Unused encoding 15 (macro off) → FETCH1.

## Timing
- Reset:
  - `state`=FETCH1 immediately and asynchronously. Outputs therefore show the FETCH1 decode while `reset` is high.
  - The datapath registers are under the same reset, so these outputs are harmless.
  - The first fetch occurs on the first rising edge after `reset` deasserts.
- `op` must be stable from DECODE until the next FETCH1. `zero` is sampled only in BEQEX/BNEEX, combinationally into `pcen`.
- Cycles per instruction, FETCH1 to the next FETCH1:
  - 8 cycles: lb.
  - 7 cycles: sb, R-type, addi.
  - 6 cycles: beq, j, bne.
  - 5 cycles: unknown opcode.
- Reset asserted mid-instruction aborts immediately. No further writes are issued; memwrite/regwrite drop the same cycle.

## Configuration
- `MAINCONTROL_BNE_EN` defined:
  - Opcode 000101 routes DECODE→BNEEX.
  - BNEEX outputs: alusrca=1, alusrcb=00, aluop=01, pcsource=01, branchne=1. Next state FETCH1.
- Undefined: 000101 is an unknown opcode (DECODE→FETCH1), encoding 15 is unreachable, and branchne is tied 0.

## Test plan
- Reset then release → `state` 0,1,2,3,4; irwrite 0001,0010,0100,1000,0000; pcen=1 on the four fetch cycles only.
- op=000000 → RTYPEEX with aluop=10, then RTYPEWR with regwrite=1, regdst=1; back at FETCH1 7 cycles after the start.
- op=100000 → MEMADR, LBRD (memread=1, iord=1), LBWR (regwrite=1, memtoreg=1) → FETCH1; total 8 cycles.
- op=000100 in BEQEX with zero=1 → pcen=1, pcsource=01, aluop=01; with zero=0 → pcen=0.
- op=111111 → DECODE→FETCH1 with no memwrite/regwrite; reset asserted in SBWR → memwrite=0 and state=0 in the same cycle.
- Macro on, op=000101, zero=0 → BNEEX with pcen=1; macro off → state goes 4→0.

Source files
------------

// File: rtl/maincontrol.sv
// rtl/maincontrol.sv - multicycle Moore main control for the 8-bit MIPS datapath; optional bne via MAINCONTROL_BNE_EN
module maincontrol (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       memtoreg,
    output logic       iord,
    output logic       regwrite,
    output logic       regdst,
    output logic [1:0] pcsource,
    output logic       pcen,
    output logic [3:0] irwrite,
    output logic [1:0] aluop,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH1  = 4'd0;
    localparam logic [3:0] FETCH2  = 4'd1;
    localparam logic [3:0] FETCH3  = 4'd2;
    localparam logic [3:0] FETCH4  = 4'd3;
    localparam logic [3:0] DECODE  = 4'd4;
    localparam logic [3:0] MEMADR  = 4'd5;
    localparam logic [3:0] LBRD    = 4'd6;
    localparam logic [3:0] LBWR    = 4'd7;
    localparam logic [3:0] SBWR    = 4'd8;
    localparam logic [3:0] RTYPEEX = 4'd9;
    localparam logic [3:0] RTYPEWR = 4'd10;
    localparam logic [3:0] BEQEX   = 4'd11;
    localparam logic [3:0] JEX     = 4'd12;
    localparam logic [3:0] ADDIEX  = 4'd13;
    localparam logic [3:0] ADDIWR  = 4'd14;
    localparam logic [3:0] BNEEX   = 4'd15;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    logic [3:0] nextstate;
    logic       pcwrite;
    logic       branch;
    logic       branchne;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH1;
        else       state <= nextstate;
    end

    always_comb begin
        nextstate = FETCH1;
        case (state)
            FETCH1:  nextstate = FETCH2;
            FETCH2:  nextstate = FETCH3;
            FETCH3:  nextstate = FETCH4;
            FETCH4:  nextstate = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: nextstate = MEMADR;
                    OP_RTYPE:     nextstate = RTYPEEX;
                    OP_BEQ:       nextstate = BEQEX;
                    OP_J:         nextstate = JEX;
                    OP_ADDI:      nextstate = ADDIEX;
`ifdef MAINCONTROL_BNE_EN
                    OP_BNE:       nextstate = BNEEX;
`endif
                    default:      nextstate = FETCH1;
                endcase
            end
            MEMADR:  nextstate = (op == OP_LB) ? LBRD : SBWR;
            LBRD:    nextstate = LBWR;
            RTYPEEX: nextstate = RTYPEWR;
            ADDIEX:  nextstate = ADDIWR;
            default: nextstate = FETCH1;
        endcase
    end

    // Pure state decode; anything not set for a state stays 0.
    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        memtoreg = 1'b0;
        iord     = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        pcsource = 2'b00;
        irwrite  = 4'b0000;
        aluop    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        branchne = 1'b0;
        case (state)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                case (state)
                    FETCH1:  irwrite = 4'b0001;
                    FETCH2:  irwrite = 4'b0010;
                    FETCH3:  irwrite = 4'b0100;
                    default: irwrite = 4'b1000;
                endcase
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            LBWR: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWR: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BEQEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsource = 2'b01;
                branch   = 1'b1;
            end
            JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            ADDIWR:  regwrite = 1'b1;
`ifdef MAINCONTROL_BNE_EN
            BNEEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsource = 2'b01;
                branchne = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign pcen = pcwrite | (branch & zero) | (branchne & ~zero);

endmodule

// File: tb/tb_maincontrol.sv
// tb/tb_maincontrol.sv - scoreboard bench for maincontrol with a per-instruction cycle model
module tb_maincontrol;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b0;
    logic       zero = 1'b0;
    logic       memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen;
    logic [1:0] alusrcb, pcsource, aluop;
    logic [3:0] irwrite, state;

    maincontrol dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .memtoreg(memtoreg), .iord(iord), .regwrite(regwrite), .regdst(regdst),
        .pcsource(pcsource), .pcen(pcen), .irwrite(irwrite), .aluop(aluop), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       memtoreg;
        logic       iord;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsource;
        logic       pcen;
        logic [3:0] irwrite;
        logic [1:0] aluop;
    } rec_t;

    rec_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_cycle = 0;
    bit   mon_en = 1'b0;

    function automatic rec_t dut_rec();
        return {state, memread, memwrite, alusrca, alusrcb, memtoreg, iord,
                regwrite, regdst, pcsource, pcen, irwrite, aluop};
    endfunction

    function automatic rec_t mk(input int st);
        rec_t r;
        r = '0;
        r.state = st[3:0];
        return r;
    endfunction

    function automatic rec_t fetch_rec(input int n);
        rec_t r;
        r = mk(n);
        r.memread = 1'b1;
        r.irwrite = 4'(1 << n);
        r.alusrcb = 2'b01;
        r.pcen    = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input rec_t got, input rec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                     name, got, got.state, exp, exp.state);
        end
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, FETCH1 up to the next FETCH1.
    task automatic model(input logic [5:0] o, input logic z, output int len);
        rec_t r;
        bit   bne_on;
`ifdef MAINCONTROL_BNE_EN
        bne_on = 1'b1;
`else
        bne_on = 1'b0;
`endif
        len = 0;
        for (int n = 0; n < 4; n++) begin q.push_back(fetch_rec(n)); len++; end
        r = mk(4); r.alusrcb = 2'b11; q.push_back(r); len++;
        if (o == 6'b100000 || o == 6'b101000) begin
            r = mk(5); r.alusrca = 1; r.alusrcb = 2'b10; q.push_back(r); len++;
            if (o == 6'b100000) begin
                r = mk(6); r.memread = 1; r.iord = 1; q.push_back(r); len++;
                r = mk(7); r.regwrite = 1; r.memtoreg = 1; q.push_back(r); len++;
            end else begin
                r = mk(8); r.memwrite = 1; r.iord = 1; q.push_back(r); len++;
            end
        end else if (o == 6'b000000) begin
            r = mk(9); r.alusrca = 1; r.aluop = 2'b10; q.push_back(r); len++;
            r = mk(10); r.regwrite = 1; r.regdst = 1; q.push_back(r); len++;
        end else if (o == 6'b000100 || (o == 6'b000101 && bne_on)) begin
            r = mk(o == 6'b000100 ? 11 : 15);
            r.alusrca = 1; r.aluop = 2'b01; r.pcsource = 2'b01;
            r.pcen = (o == 6'b000100) ? z : ~z;
            q.push_back(r); len++;
        end else if (o == 6'b000010) begin
            r = mk(12); r.pcen = 1; r.pcsource = 2'b10; q.push_back(r); len++;
        end else if (o == 6'b001000) begin
            r = mk(13); r.alusrca = 1; r.alusrcb = 2'b10; q.push_back(r); len++;
            r = mk(14); r.regwrite = 1; q.push_back(r); len++;
        end
    endtask

    task automatic issue(input logic [5:0] o, input logic z);
        int len;
        model(o, z, len);
        op   = o;
        zero = z;
        repeat (len) @(posedge clk) #1;
    endtask

    // Monitor: one expected record per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cycle++;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: cycle %0d state %0d with no expectation queued", n_cycle, state);
            end else begin
                check($sformatf("cycle_%0d", n_cycle), dut_rec(), q.pop_front());
            end
        end
    end

    logic [5:0] known [7] = '{6'b100000, 6'b101000, 6'b000000, 6'b000100,
                              6'b000010, 6'b001000, 6'b000101};

    initial begin
        rec_t r;
        #2;
        check("reset_fetch1_decode", dut_rec(), fetch_rec(0));
        @(posedge clk) #1;
        check("reset_held", dut_rec(), fetch_rec(0));
        reset = 1'b0;
        mon_en = 1'b1;

        issue(6'b000000, 1'b0);
        issue(6'b100000, 1'b0);
        issue(6'b000100, 1'b1);
        issue(6'b000100, 1'b0);
        issue(6'b111111, 1'b0);
        issue(6'b000101, 1'b0);
        issue(6'b000101, 1'b1);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) != 0) issue(known[$urandom_range(0, 6)], 1'($urandom_range(0, 1)));
            else                           issue(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        end

        // Abort a store in SBWR: six cycles reach SBWR, then reset mid-cycle.
        for (int n = 0; n < 4; n++) q.push_back(fetch_rec(n));
        r = mk(4); r.alusrcb = 2'b11; q.push_back(r);
        r = mk(5); r.alusrca = 1; r.alusrcb = 2'b10; q.push_back(r);
        op = 6'b101000;
        repeat (6) @(posedge clk) #1;
        mon_en = 1'b0;
        r = mk(8); r.memwrite = 1; r.iord = 1;
        check("sbwr_before_reset", dut_rec(), r);
        reset = 1'b1;
        #1;
        check("sbwr_reset_abort", dut_rec(), fetch_rec(0));
        @(posedge clk) #1;
        reset = 1'b0;
        mon_en = 1'b1;

        issue(6'b001000, 1'b0);
        q.push_back(fetch_rec(0));
        @(posedge clk) #1;
        mon_en = 1'b0;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d records left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
